// File: rtl/ft_recovery_ctrl.sv
// Lockstep recovery controller: halts both cores, replays golden registers, restores PC, resumes.
// Optional watchdog enabled by defining FT_RECOVERY_TIMEOUT_EN.
module ft_recovery_ctrl #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  halt_i,
   input  logic                  shift_i,
   input  logic                  resume_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic [DATA_WIDTH-1:0] spc_i,
   input  logic                  core_halted_i,
   output logic                  core_halt_o,
   output logic                  rf_we_o,
   output logic [ADDR_WIDTH-1:0] rf_addr_o,
   output logic [DATA_WIDTH-1:0] rf_wdata_o,
   output logic                  pc_we_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   output logic                  core_resume_o,
   output logic                  busy_o,
   output logic                  drop_o,
   output logic                  error_o,
   output logic [7:0]            recoveries_o
);

   localparam logic [ADDR_WIDTH:0] LAST_BEAT = (ADDR_WIDTH+1)'(2**ADDR_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      HALT_REQ,
      RESTORE,
      PC_WR,
      RESUME
   } state_e;

   state_e                state_q;
   logic [ADDR_WIDTH:0]   beat_cnt_q;
   logic                  finish_q;
   logic [DATA_WIDTH-1:0] pc_q;
   logic                  timeout;

   assign pc_o   = pc_q;
   assign busy_o = (state_q != IDLE);

`ifdef FT_RECOVERY_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT + 1);

   logic [WDOG_W-1:0] wdog_q;
   logic              error_q;
   logic              stall;

   assign stall = ((state_q == HALT_REQ) && !core_halted_i) ||
                  ((state_q == RESTORE) && !finish_q && !shift_i && !resume_i);
   assign timeout = stall && (wdog_q == WDOG_W'(TIMEOUT - 1));
   assign error_o = error_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wdog_q  <= '0;
         error_q <= 1'b0;
      end else if (timeout) begin
         wdog_q  <= '0;
         error_q <= 1'b1;
      end else if (stall) begin
         wdog_q  <= wdog_q + 1'b1;
      end else begin
         wdog_q  <= '0;
      end
   end
`else
   assign timeout = 1'b0;
   assign error_o = 1'b0;
`endif

   // NOTE: all state and outputs use non-blocking assignments and are cleared by the async reset,
   // so an aborted recovery leaves no halt, write or resume request behind.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         finish_q      <= 1'b0;
         pc_q          <= '0;
         core_halt_o   <= 1'b0;
         rf_we_o       <= 1'b0;
         rf_addr_o     <= '0;
         rf_wdata_o    <= '0;
         pc_we_o       <= 1'b0;
         core_resume_o <= 1'b0;
         drop_o        <= 1'b0;
         recoveries_o  <= '0;
      end else begin
         rf_we_o       <= 1'b0;
         pc_we_o       <= 1'b0;
         core_resume_o <= 1'b0;

         // Beats that cannot be written (wrong state or restore already closing) are flagged.
         if (shift_i && !((state_q == RESTORE) && !finish_q))
            drop_o <= 1'b1;

         case (state_q)
            IDLE: begin
               if (halt_i) begin
                  pc_q        <= spc_i;
                  core_halt_o <= 1'b1;
                  state_q     <= HALT_REQ;
               end
            end

            HALT_REQ: begin
               if (core_halted_i) begin
                  state_q <= RESTORE;
               end else if (timeout) begin
                  core_halt_o   <= 1'b0;
                  core_resume_o <= 1'b1;
                  state_q       <= RESUME;
               end
            end

            RESTORE: begin
               if (finish_q) begin
                  // The last beat's write has already been issued; PC write follows it.
                  finish_q <= 1'b0;
                  pc_we_o  <= 1'b1;
                  state_q  <= PC_WR;
               end else if (timeout) begin
                  core_halt_o   <= 1'b0;
                  core_resume_o <= 1'b1;
                  state_q       <= RESUME;
               end else begin
                  if (shift_i) begin
                     rf_we_o    <= 1'b1;
                     rf_addr_o  <= addr_i;
                     rf_wdata_o <= data_i;
                     beat_cnt_q <= beat_cnt_q + 1'b1;
                  end
                  if ((shift_i && (beat_cnt_q == LAST_BEAT)) || resume_i)
                     finish_q <= 1'b1;
               end
            end

            PC_WR: begin
               core_halt_o   <= 1'b0;
               core_resume_o <= 1'b1;
               if (recoveries_o != 8'hFF)
                  recoveries_o <= recoveries_o + 8'd1;
               state_q       <= RESUME;
            end

            RESUME: begin
               beat_cnt_q <= '0;
               state_q    <= IDLE;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
